// File: rtl/axil_read_addr_fifo.sv
`default_nettype none
// ============================================================================
// Module      : axil_read_addr_fifo
// Description : AXI4-Lite read-address (AR) channel buffer. Holds up to DEPTH
//               beats (address + ARPROT) so that upstream ARREADY is decoupled
//               from downstream backpressure. Output addresses have their
//               ALIGN_LSB low bits cleared; an occupancy count is exported.
// Ports       : ACLK, ARESETn         clock / async active-high reset
//               s_ar{valid,ready,addr,prot}   upstream AR slave port
//               m_ar{valid,ready,addr,prot}   downstream AR master port
//               count, full, empty    occupancy status
// Revision    : 1.0 - initial release
// ============================================================================
module axil_read_addr_fifo #(
  parameter int ADDR_W    = 32,
  parameter int DEPTH     = 4,
  parameter int ALIGN_LSB = 2,
  parameter int CNT_W     = $clog2(DEPTH) + 1
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic              s_arvalid,
  output logic              s_arready,
  input  logic [ADDR_W-1:0] s_araddr,
  input  logic [2:0]        s_arprot,
  output logic              m_arvalid,
  input  logic              m_arready,
  output logic [ADDR_W-1:0] m_araddr,
  output logic [2:0]        m_arprot,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);
  // Low ALIGN_LSB bits cleared; ALIGN_LSB = 0 gives an all-ones mask.
  localparam logic [ADDR_W-1:0] ADDR_MASK = ~((ADDR_W'(1) << ALIGN_LSB) - ADDR_W'(1));

  logic [ADDR_W+2:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wptr_q, wptr_d;
  logic [PTR_W-1:0]  rptr_q, rptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              push, pop;
  logic [ADDR_W+2:0] head;

  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;

  // Ready comes only from registered occupancy, so there is no path from
  // m_arready to s_arready.
  assign s_arready = !full && !ARESETn;
  assign m_arvalid = !empty;

  assign push = s_arvalid && s_arready;
  assign pop  = m_arvalid && m_arready;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    // Power-of-two depth: pointer overflow is the modulo-DEPTH wrap.
    if (push) wptr_d = wptr_q + PTR_W'(1);
    if (pop)  rptr_d = rptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESETn) begin
    if (ARESETn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: occupancy alone decides which slots are live,
  // and push is blocked while reset is asserted.
  always_ff @(posedge ACLK) begin
    if (push) mem_q[wptr_q] <= {s_arprot, s_araddr};
  end

  assign head = mem_q[rptr_q];

  // Outputs are forced to zero only during reset; otherwise they follow the
  // head slot (meaningful only while m_arvalid is high).
  assign m_araddr = ARESETn ? '0 : (head[ADDR_W-1:0] & ADDR_MASK);
  assign m_arprot = ARESETn ? '0 : head[ADDR_W+2:ADDR_W];

endmodule
`default_nettype wire
